// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the serial debug unit.
// Holds the byte width, the default handshake timeouts (also used by the
// rx-side controllers) and the tx arbiter state encoding.
package uart_dbg_pkg;

   localparam int          UART_BYTE_W = 8;
   localparam int          DEF_ACK_TO  = 4;
   localparam logic [31:0] DEF_HOLD_TO = 32'd1_000_000;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      ACK,
      DRAIN,
      HOLD
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this round
//   win : one-hot winner, the first set bit at or above ptr (wrapping), or 0
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         win
);

   localparam int PTR_W = $clog2(N_REQ);

   logic [PTR_W-1:0] idx;

   // Scan from the lowest priority offset down, so the last hit written
   // is the closest one to ptr.
   always_comb begin
      win = '0;
      idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(ptr) + k) % N_REQ);
         if (req[idx]) begin
            win      = '0;
            win[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte-stream requesters. Ownership is
// granted round-robin per message (a message ends with req_last) and held
// until the last byte or until the owner goes quiet for HOLD_TO cycles.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_vld/data/last   : per-requester byte offer (data packed 8 bits each)
//   req_rdy             : one-cycle pulse, byte of requester i taken
//   d_tx, vld_tx        : byte and one-cycle strobe to uart_tx
//   rdy_tx              : uart_tx idle (1) / shifting (0)
//   grant               : one-hot current owner, 0 when unlocked
//   busy                : arbiter not idle
module uart_tx_arbiter
   import uart_dbg_pkg::*;
#(
   parameter int          N_REQ   = 4,
   parameter int          ACK_TO  = DEF_ACK_TO,
   parameter logic [31:0] HOLD_TO = DEF_HOLD_TO
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_vld,
   input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]             req_last,
   output logic [N_REQ-1:0]             req_rdy,
   output logic [UART_BYTE_W-1:0]       d_tx,
   output logic                         vld_tx,
   input  logic                         rdy_tx,
   output logic [N_REQ-1:0]             grant,
   output logic                         busy
);

   localparam int               PTR_W     = $clog2(N_REQ);
   localparam int               ACK_W     = $clog2(ACK_TO + 1);
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
   localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TO - 1);
   localparam logic [31:0]      HOLD_LAST = HOLD_TO - 32'd1;

   arb_state_t             state, state_n;
   logic [N_REQ-1:0]       grant_n, req_rdy_n, win;
   logic [PTR_W-1:0]       gidx, gidx_n, rr_ptr, rr_ptr_n, win_idx, ptr_after;
   logic [UART_BYTE_W-1:0] d_tx_n;
   logic                   last_q, last_n, vld_n;
   logic [ACK_W-1:0]       ack_cnt, ack_n;
   logic [31:0]            hold_cnt, hold_n;

   logic [N_REQ-1:0][UART_BYTE_W-1:0] req_byte;
   assign req_byte = req_data;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (req_vld),
      .ptr (rr_ptr),
      .win (win)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (win[i]) win_idx = PTR_W'(i);
   end

   // Priority after the current owner finishes or is dropped.
   assign ptr_after = (gidx == LAST_IDX) ? '0 : gidx + PTR_W'(1);

   always_comb begin
      state_n   = state;
      grant_n   = grant;
      gidx_n    = gidx;
      rr_ptr_n  = rr_ptr;
      last_n    = last_q;
      d_tx_n    = d_tx;
      ack_n     = ack_cnt;
      hold_n    = hold_cnt;
      vld_n     = 1'b0;
      req_rdy_n = '0;

      case (state)
         IDLE: begin
            if (rdy_tx && |req_vld) begin
               grant_n = win;
               gidx_n  = win_idx;
               d_tx_n  = req_byte[win_idx];
               last_n  = req_last[win_idx];
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            ack_n   = '0;
            state_n = ACK;
         end
         ACK: begin
            // A transmitter that never drops rdy_tx must not stall us.
            if (!rdy_tx || ack_cnt >= ACK_LAST) state_n = DRAIN;
            else                                ack_n   = ack_cnt + ACK_W'(1);
         end
         DRAIN: begin
            if (rdy_tx) begin
               if (last_q) begin
                  rr_ptr_n = ptr_after;
                  grant_n  = '0;
                  state_n  = IDLE;
               end else begin
                  hold_n  = '0;
                  state_n = HOLD;
               end
            end
         end
         HOLD: begin
            // Only the owner may continue; everyone else waits.
            if (req_vld[gidx]) begin
               d_tx_n  = req_byte[gidx];
               last_n  = req_last[gidx];
               hold_n  = '0;
               state_n = ISSUE;
            end else if (hold_cnt >= HOLD_LAST) begin
               grant_n  = '0;
               rr_ptr_n = ptr_after;
               hold_n   = '0;
               state_n  = IDLE;
            end else if (hold_cnt != '1) begin
               hold_n = hold_cnt + 32'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Strobes are registered: they are high for the whole ISSUE cycle.
      if (state_n == ISSUE) begin
         vld_n     = 1'b1;
         req_rdy_n = grant_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         gidx     <= '0;
         rr_ptr   <= '0;
         last_q   <= 1'b0;
         d_tx     <= '0;
         ack_cnt  <= '0;
         hold_cnt <= '0;
         vld_tx   <= 1'b0;
         req_rdy  <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         gidx     <= gidx_n;
         rr_ptr   <= rr_ptr_n;
         last_q   <= last_n;
         d_tx     <= d_tx_n;
         ack_cnt  <= ack_n;
         hold_cnt <= hold_n;
         vld_tx   <= vld_n;
         req_rdy  <= req_rdy_n;
         busy     <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a uart_tx timing model and a
// message-level round-robin reference model.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int ACKT  = 4;
   localparam int HOLDT = 16;

   logic           clk = 1'b0, rst = 1'b1;
   logic [N-1:0]   req_vld = '0, req_last = '0, req_rdy, grant;
   logic [8*N-1:0] req_data = '0;
   logic [7:0]     d_tx;
   logic           vld_tx, rdy_tx, busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .ACK_TO(ACKT), .HOLD_TO(32'(HOLDT))) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
      .req_last(req_last), .req_rdy(req_rdy), .d_tx(d_tx), .vld_tx(vld_tx),
      .rdy_tx(rdy_tx), .grant(grant), .busy(busy)
   );

   typedef logic [8:0] q_t[$];   // bit 8 = last
   typedef struct {int owner; logic [7:0] data; int cyc;} obs_t;
   typedef struct {logic [3:0] mask; int n; int ord[4]; int ptr;} vec_t;

   q_t   rq [N];
   obs_t obs[$];
   obs_t expq[$];
   int   cyc = 0, tx_cnt = 0, tx_len = 3, rdy_pulses = 0;
   int   passed = 0, total = 0, model_ptr = 0, rise0 = -1;
   bit   tx_stuck = 0, tx_low = 0;

   // uart_tx model: goes busy for tx_len cycles after each strobe.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_cnt > 0)                tx_cnt <= tx_cnt - 1;
      else if (vld_tx && !tx_stuck)  tx_cnt <= tx_len;
   end
   assign rdy_tx = (tx_cnt == 0) && !tx_low;

   function automatic int oh2i(input logic [N-1:0] g);
      int r = -1, n = 0;
      for (int i = 0; i < N; i++) if (g[i]) begin r = i; n++; end
      return (n == 1) ? r : -1;
   endfunction

   // Monitor and requester drivers.
   always @(negedge clk) begin
      if (vld_tx) obs.push_back('{oh2i(grant), d_tx, cyc});
      for (int i = 0; i < N; i++) begin
         if (req_rdy[i]) begin
            rdy_pulses++;
            if (rq[i].size() > 0) void'(rq[i].pop_front());
         end
         if (rq[i].size() > 0) begin
            req_vld[i]         = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]        = rq[i][0][8];
         end else begin
            req_vld[i]         = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
      if (req_vld[0] && rise0 < 0) rise0 = cyc;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic do_reset();
      for (int i = 0; i < N; i++) rq[i].delete();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n = 0;
      @(negedge clk);
      while ((pending() || busy || tx_cnt != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " timeout"}, 32'(n >= budget), 32'd0);
   endtask

   // Whole messages go out one requester at a time, picked round-robin.
   task automatic model_expect();
      q_t mq [N];
      int g, idx;
      logic [8:0] b;
      expq.delete();
      for (int i = 0; i < N; i++) mq[i] = rq[i];
      for (int guard = 0; guard < 1000; guard++) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            idx = (model_ptr + k) % N;
            if (g < 0 && mq[idx].size() > 0) g = idx;
         end
         if (g < 0) break;
         for (int guard2 = 0; guard2 < 1000; guard2++) begin
            if (mq[g].size() == 0) break;
            b = mq[g].pop_front();
            expq.push_back('{g, b[7:0], 0});
            if (b[8]) break;
         end
         model_ptr = (g + 1) % N;
      end
   endtask

   task automatic run_check(input string nm);
      model_expect();
      obs.delete();
      rdy_pulses = 0;
      wait_idle(4000, nm);
      chk({nm, " bytes"}, obs.size(), expq.size());
      for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
         chk($sformatf("%s owner[%0d]", nm, i), obs[i].owner, expq[i].owner);
         chk($sformatf("%s data[%0d]", nm, i), obs[i].data, expq[i].data);
      end
      chk({nm, " req_rdy pulses"}, rdy_pulses, expq.size());
      chk({nm, " rr_ptr"}, 32'(dut.rr_ptr), model_ptr);
      chk({nm, " grant idle"}, 32'(grant), 32'd0);
   endtask

   vec_t tbl [8];

   initial begin
      // Simultaneous one-byte offers; rr_ptr carries from row to row.
      tbl[0] = '{4'b1111, 4, '{0, 1, 2, 3}, 0};
      tbl[1] = '{4'b0101, 2, '{0, 2, 0, 0}, 3};
      tbl[2] = '{4'b0011, 2, '{0, 1, 0, 0}, 2};
      tbl[3] = '{4'b1001, 2, '{3, 0, 0, 0}, 1};
      tbl[4] = '{4'b0110, 2, '{1, 2, 0, 0}, 3};
      tbl[5] = '{4'b1100, 2, '{3, 2, 0, 0}, 3};
      tbl[6] = '{4'b0001, 1, '{0, 0, 0, 0}, 1};
      tbl[7] = '{4'b1111, 4, '{1, 2, 3, 0}, 1};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset grant", 32'(grant), 32'd0);
      chk("reset req_rdy", 32'(req_rdy), 32'd0);
      chk("reset vld_tx", 32'(vld_tx), 32'd0);
      chk("reset d_tx", 32'(d_tx), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset rr_ptr", 32'(dut.rr_ptr), 32'd0);
      rst = 1'b0;
      model_ptr = 0;
      @(negedge clk);

      // Transmitter busy while idle: request must wait.
      tx_low = 1'b1;
      obs.delete();
      rq[0].push_back(9'h141);
      repeat (6) @(negedge clk);
      chk("tx busy: grant", 32'(grant), 32'd0);
      chk("tx busy: no strobe", obs.size(), 32'd0);
      chk("tx busy: busy", 32'(busy), 32'd0);
      tx_low = 1'b0;
      run_check("tx busy release");

      // Single byte, long transmit; latency from offer to strobe.
      do_reset();
      tx_len = 10;
      rise0 = -1;
      rq[0].push_back(9'h141);
      run_check("single");
      if (obs.size() > 0) chk("single latency", obs[0].cyc - rise0, 32'd1);

      // Table of simultaneous requests.
      do_reset();
      tx_len = 2;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++)
            if (tbl[r].mask[i]) rq[i].push_back({1'b1, 8'hA0 + 8'(i)});
         run_check($sformatf("tbl%0d", r));
         for (int k = 0; k < tbl[r].n && k < obs.size(); k++)
            chk($sformatf("tbl%0d order[%0d]", r, k), obs[k].owner, tbl[r].ord[k]);
         chk($sformatf("tbl%0d ptr", r), 32'(dut.rr_ptr), tbl[r].ptr);
      end

      // Two 3-byte messages, never interleaved.
      do_reset();
      tx_len = 10;
      rq[0].push_back(9'h001); rq[0].push_back(9'h002); rq[0].push_back(9'h103);
      rq[2].push_back(9'h021); rq[2].push_back(9'h022); rq[2].push_back(9'h123);
      run_check("two msgs");

      // Owner stalls mid-message; lock must hold, then time out.
      do_reset();
      tx_len = 3;
      obs.delete();
      rq[1].push_back(9'h010);
      rq[3].push_back(9'h133);
      for (int n = 0; n < 50 && obs.size() == 0; n++) @(negedge clk);
      repeat (10) @(negedge clk);
      chk("hold grant", 32'(grant), 32'b0010);
      chk("hold busy", 32'(busy), 32'd1);
      chk("hold blocks other", obs.size(), 32'd1);
      wait_idle(200, "hold");
      chk("hold bytes", obs.size(), 32'd2);
      if (obs.size() >= 2) begin
         chk("hold owner0", obs[0].owner, 32'd1);
         chk("hold data0", obs[0].data, 32'h10);
         chk("hold owner1", obs[1].owner, 32'd3);
         chk("hold data1", obs[1].data, 32'h33);
         chk("hold gap in range",
             32'((obs[1].cyc - obs[0].cyc) > HOLDT && (obs[1].cyc - obs[0].cyc) <= HOLDT + 12), 32'd1);
      end
      chk("hold rr_ptr", 32'(dut.rr_ptr), 32'd0);

      // Transmitter never drops rdy_tx: ACK timeout paces the bytes.
      do_reset();
      tx_stuck = 1'b1;
      rq[2].push_back(9'h031); rq[2].push_back(9'h032); rq[2].push_back(9'h133);
      run_check("stuck");
      if (obs.size() >= 3) begin
         chk("stuck spacing1", obs[1].cyc - obs[0].cyc, ACKT + 3);
         chk("stuck spacing2", obs[2].cyc - obs[1].cyc, ACKT + 3);
      end
      tx_stuck = 1'b0;

      // Reset while waiting for acknowledge.
      do_reset();
      tx_len = 10;
      obs.delete();
      rq[2].push_back(9'h051); rq[2].push_back(9'h152);
      for (int n = 0; n < 50 && obs.size() == 0; n++) @(negedge clk);
      @(negedge clk);
      chk("rst-in-ack grant before", 32'(grant), 32'b0100);
      rst = 1'b1;
      @(negedge clk);
      chk("rst-in-ack grant", 32'(grant), 32'd0);
      chk("rst-in-ack busy", 32'(busy), 32'd0);
      chk("rst-in-ack vld_tx", 32'(vld_tx), 32'd0);
      chk("rst-in-ack rr_ptr", 32'(dut.rr_ptr), 32'd0);
      rst = 1'b0;
      model_ptr = 0;
      @(negedge clk);
      chk("post-rst vld_tx", 32'(vld_tx), 32'd0);
      run_check("rearb after rst");

      // All requesters continuously offering one-byte messages.
      do_reset();
      tx_len = 1;
      for (int i = 0; i < N; i++) begin
         rq[i].push_back({1'b1, 8'hC0 + 8'(i)});
         rq[i].push_back({1'b1, 8'hD0 + 8'(i)});
      end
      run_check("all4");
      for (int k = 0; k < 5 && k < obs.size(); k++)
         chk($sformatf("all4 order[%0d]", k), obs[k].owner, k % 4);

      // Randomized message mixes.
      for (int it = 0; it < 8; it++) begin
         int nm, len;
         do_reset();
         tx_len = $urandom_range(1, 6);
         for (int i = 0; i < N; i++) begin
            nm = $urandom_range(0, 2);
            for (int m = 0; m < nm; m++) begin
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++)
                  rq[i].push_back({b == len - 1, 8'($urandom)});
            end
         end
         run_check($sformatf("rand%0d", it));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
